// File: rtl/counter_pkg.sv
// counter_pkg: shared widths and timestamp layout for the counter capture stage
package counter_pkg;
    localparam int CNT_W_DEF   = 8;
    localparam int EPOCH_W_DEF = 4;
    localparam int TS_W        = EPOCH_W_DEF + CNT_W_DEF;
    typedef struct packed {
        logic [EPOCH_W_DEF-1:0] epoch;
        logic [CNT_W_DEF-1:0]   count;
    } ts_t;
endpackage

// File: rtl/capture_sync_fifo.sv
// capture_sync_fifo: synchronous FIFO with push/pop, occupancy level and head output
module capture_sync_fifo
    import counter_pkg::*;
#(
    parameter int W     = TS_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    always_comb begin
        head  = mem[rptr];
        valid = level != '0;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
    // Occupancy is tracked separately so full and empty are unambiguous with equal pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= push ? wptr + AW'(1) : wptr;
            rptr  <= pop ? rptr + AW'(1) : rptr;
            level <= level + LW'(push & ~pop) - LW'(pop & ~push);
        end
    end
endmodule

// File: rtl/counter8_capture_fifo.sv
// counter8_capture_fifo: epoch-extended timestamp capture on trigger edges, queued for a consumer
module counter8_capture_fifo
    import counter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int EPOCH_W = EPOCH_W_DEF,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CNT_W-1:0]           count,
    input  logic                       trig,
    input  logic                       ovf_clr,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [EPOCH_W+CNT_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic               trig_q, trig_rise, wrap, pop, push, full;
    logic [CNT_W-1:0]   count_q;
    logic [EPOCH_W-1:0] epoch, epoch_ts;
    always_comb begin
        trig_rise = trig & ~trig_q;
        wrap      = (count_q == '1) && (count == '0);
        epoch_ts  = epoch + EPOCH_W'(wrap);
        full      = level == LW'(DEPTH);
        pop       = rd_valid & rd_ready;
        push      = trig_rise & (~full | pop);
    end
    // trig_q resets high so a trigger held through reset is not seen as an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q   <= 1'b1;
            count_q  <= '0;
            epoch    <= '0;
            overflow <= 1'b0;
        end else begin
            trig_q   <= trig;
            count_q  <= count;
            epoch    <= epoch_ts;
            overflow <= (trig_rise & ~push) | (overflow & ~ovf_clr);
        end
    end
    capture_sync_fifo #(
        .W     (EPOCH_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({epoch_ts, count}),
        .head  (rd_data),
        .valid (rd_valid),
        .level (level)
    );
endmodule

// File: tb/tb_counter8_capture_fifo.sv
// tb_counter8_capture_fifo: directed vector table plus wrap/epoch and reset sequences
module tb_counter8_capture_fifo;
    logic        clk = 1'b0;
    logic        reset, trig, ovf_clr, rd_ready;
    logic [7:0]  count;
    logic        rd_valid, overflow;
    logic [11:0] rd_data;
    logic [2:0]  level;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [7:0]  cnt;
        logic        trg;
        logic        clr;
        logic        rdy;
        logic        v;
        logic [11:0] d;
        logic [2:0]  l;
        logic        o;
    } vec_t;
    vec_t tbl[$];

    counter8_capture_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .trig     (trig),
        .ovf_clr  (ovf_clr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic [7:0] c, input logic t, input logic cl, input logic rd);
        reset    = r;
        count    = c;
        trig     = t;
        ovf_clr  = cl;
        rd_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic v, input logic [11:0] d, input logic [2:0] l, input logic o);
        checks++;
        if (rd_valid !== v) begin
            errors++;
            $display("FAIL %s rd_valid got %0b exp %0b", nm, rd_valid, v);
        end
        checks++;
        if (level !== l) begin
            errors++;
            $display("FAIL %s level got %0d exp %0d", nm, level, l);
        end
        checks++;
        if (overflow !== o) begin
            errors++;
            $display("FAIL %s overflow got %0b exp %0b", nm, overflow, o);
        end
        if (v) begin
            checks++;
            if (rd_data !== d) begin
                errors++;
                $display("FAIL %s rd_data got %03h exp %03h", nm, rd_data, d);
            end
        end
    endtask

    task automatic add(input logic r, input logic [7:0] c, input logic t, input logic cl, input logic rd,
                       input logic v, input logic [11:0] d, input logic [2:0] l, input logic o);
        vec_t e;
        e.rst = r; e.cnt = c; e.trg = t; e.clr = cl; e.rdy = rd;
        e.v = v; e.d = d; e.l = l; e.o = o;
        tbl.push_back(e);
    endtask

    initial begin
        reset = 1'b1; count = 8'h10; trig = 1'b1; ovf_clr = 1'b0; rd_ready = 1'b0;
        // rst cnt trig clr rdy | valid data level ovf
        add(1, 8'h10, 1, 0, 0,  0, 12'h000, 3'd0, 0);
        add(0, 8'h10, 1, 0, 0,  0, 12'h000, 3'd0, 0);
        add(0, 8'h10, 0, 0, 0,  0, 12'h000, 3'd0, 0);
        add(0, 8'h2A, 1, 0, 0,  1, 12'h02A, 3'd1, 0);
        add(0, 8'h2A, 1, 0, 1,  0, 12'h000, 3'd0, 0);
        add(0, 8'h2A, 0, 0, 0,  0, 12'h000, 3'd0, 0);
        add(0, 8'h01, 1, 0, 0,  1, 12'h001, 3'd1, 0);
        add(0, 8'h02, 0, 0, 0,  1, 12'h001, 3'd1, 0);
        add(0, 8'h03, 1, 0, 0,  1, 12'h001, 3'd2, 0);
        add(0, 8'h04, 0, 0, 0,  1, 12'h001, 3'd2, 0);
        add(0, 8'h05, 1, 0, 0,  1, 12'h001, 3'd3, 0);
        add(0, 8'h06, 0, 0, 0,  1, 12'h001, 3'd3, 0);
        add(0, 8'h07, 1, 0, 0,  1, 12'h001, 3'd4, 0);
        add(0, 8'h08, 0, 0, 0,  1, 12'h001, 3'd4, 0);
        add(0, 8'h09, 1, 0, 0,  1, 12'h001, 3'd4, 1);
        add(0, 8'h0A, 0, 0, 1,  1, 12'h003, 3'd3, 1);
        add(0, 8'h0A, 0, 0, 1,  1, 12'h005, 3'd2, 1);
        add(0, 8'h0A, 0, 0, 1,  1, 12'h007, 3'd1, 1);
        add(0, 8'h0A, 0, 0, 1,  0, 12'h000, 3'd0, 1);
        add(0, 8'h0A, 0, 0, 1,  0, 12'h000, 3'd0, 1);
        add(0, 8'h0A, 0, 1, 0,  0, 12'h000, 3'd0, 0);
        add(0, 8'h11, 1, 0, 0,  1, 12'h011, 3'd1, 0);
        add(0, 8'h12, 0, 0, 0,  1, 12'h011, 3'd1, 0);
        add(0, 8'h13, 1, 0, 0,  1, 12'h011, 3'd2, 0);
        add(0, 8'h14, 0, 0, 0,  1, 12'h011, 3'd2, 0);
        add(0, 8'h15, 1, 0, 0,  1, 12'h011, 3'd3, 0);
        add(0, 8'h16, 0, 0, 0,  1, 12'h011, 3'd3, 0);
        add(0, 8'h17, 1, 0, 0,  1, 12'h011, 3'd4, 0);
        add(0, 8'h18, 0, 0, 0,  1, 12'h011, 3'd4, 0);
        add(0, 8'h40, 1, 0, 1,  1, 12'h013, 3'd4, 0);
        add(0, 8'h41, 0, 0, 0,  1, 12'h013, 3'd4, 0);
        add(0, 8'h42, 1, 1, 0,  1, 12'h013, 3'd4, 1);
        add(0, 8'h43, 0, 0, 1,  1, 12'h015, 3'd3, 1);
        add(0, 8'h43, 0, 0, 1,  1, 12'h017, 3'd2, 1);
        add(0, 8'h43, 0, 0, 1,  1, 12'h040, 3'd1, 1);
        add(0, 8'h43, 0, 0, 1,  0, 12'h000, 3'd0, 1);
        add(0, 8'h50, 1, 0, 0,  1, 12'h050, 3'd1, 1);
        add(0, 8'h51, 0, 0, 0,  1, 12'h050, 3'd1, 1);
        add(0, 8'h52, 1, 0, 0,  1, 12'h050, 3'd2, 1);
        add(0, 8'h53, 0, 0, 0,  1, 12'h050, 3'd2, 1);
        add(0, 8'h54, 1, 0, 0,  1, 12'h050, 3'd3, 1);
        add(1, 8'h55, 0, 0, 0,  0, 12'h000, 3'd0, 0);
        add(0, 8'h06, 0, 0, 0,  0, 12'h000, 3'd0, 0);
        add(0, 8'h07, 1, 0, 0,  1, 12'h007, 3'd1, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].cnt, tbl[i].trg, tbl[i].clr, tbl[i].rdy);
            chk($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o);
        end

        drive(0, 8'h00, 0, 0, 1); chk("drain007", 0, 12'h000, 3'd0, 0);
        drive(0, 8'hFF, 0, 0, 0); chk("pre_wrap", 0, 12'h000, 3'd0, 0);
        drive(0, 8'h00, 1, 0, 0); chk("wrap_cap", 1, 12'h100, 3'd1, 0);
        drive(0, 8'h01, 0, 0, 1); chk("wrap_pop", 0, 12'h000, 3'd0, 0);
        drive(0, 8'h05, 1, 0, 0); chk("epoch1_cap", 1, 12'h105, 3'd1, 0);
        drive(0, 8'h06, 0, 0, 1); chk("epoch1_pop", 0, 12'h000, 3'd0, 0);
        drive(0, 8'h80, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0); chk("nonwrap_zero", 1, 12'h100, 3'd1, 0);
        drive(0, 8'h00, 0, 0, 1); chk("nonwrap_pop", 0, 12'h000, 3'd0, 0);
        for (int i = 0; i < 15; i++) begin
            drive(0, 8'hFF, 0, 0, 0);
            drive(0, 8'h00, 0, 0, 0);
        end
        drive(0, 8'h05, 1, 0, 0); chk("epoch_rollover", 1, 12'h005, 3'd1, 0);
        drive(0, 8'hFF, 0, 0, 1); chk("roll_pop", 0, 12'h000, 3'd0, 0);
        drive(0, 8'h00, 0, 0, 0);
        drive(0, 8'h21, 1, 0, 0); chk("epoch1_again", 1, 12'h121, 3'd1, 0);
        drive(1, 8'h22, 1, 0, 0); chk("reset_epoch", 0, 12'h000, 3'd0, 0);
        drive(0, 8'h06, 0, 0, 0); chk("post_reset", 0, 12'h000, 3'd0, 0);
        drive(0, 8'h07, 1, 0, 0); chk("epoch_cleared", 1, 12'h007, 3'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter8_capture_fifo.md
Name: counter8_capture_fifo

Overview:
- Timestamp-capture stage placed directly downstream of the 8-bit free-running counter.
- Samples the counter value on each rising edge of a trigger and extends it with a 4-bit wrap epoch.
- Queues the resulting 12-bit timestamps in a small FIFO, which a consumer drains over a valid/ready handshake.
- Flags lost captures with a sticky overflow bit.

Parameters:
- CNT_W, 8, width of the incoming counter value.
- EPOCH_W, 4, width of the wrap-epoch extension.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- count  input  CNT_W  live counter value, valid every cycle.
- trig  input  1  capture request, synchronous to clk; only its rising edge acts.
- ovf_clr  input  1  one-cycle pulse that clears the overflow flag.
- rd_ready  input  1  consumer accepts the head entry.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  EPOCH_W+CNT_W  head timestamp, packed as {epoch, count}.
- level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a capture was dropped.

Behaviour:
- Reset (synchronous, reset=1 at a posedge):
  - level=0, rd_valid=0, overflow=0, epoch=0, count_q=0.
  - trig_q=1, so a trig held high through reset does not capture.
  - rd_data contents are don't-care while rd_valid=0.
- Edge detect: edge = trig & ~trig_q; trig_q <= trig every cycle.
- Wrap detect:
  - wrap = (count_q == 2^CNT_W-1) & (count == 0); count_q <= count every cycle.
  - On wrap, epoch <= epoch+1 modulo 2^EPOCH_W.
  - A counter reset to 0 from any value other than 255 is not a wrap.
- Timestamp = {epoch + wrap, count}. A capture in the same cycle as a wrap carries the already-incremented epoch.
- Push/pop rules:
  - pop = rd_valid & rd_ready.
  - push = edge & (level < DEPTH | pop).
  - Both may occur in the same cycle: level is unchanged and order is preserved.
- Full: an edge with level==DEPTH and no pop is dropped, and overflow <= 1.
- Overflow priority: a drop and ovf_clr in the same cycle leaves overflow=1 (set wins).
- Empty: rd_ready while rd_valid=0 is ignored and level stays 0. A push into an empty FIFO is not bypassed.
- Latency: edge at posedge N → rd_valid=1 and rd_data valid after posedge N+1 (one cycle).
- rd_data is stable while rd_valid=1 and rd_ready=0.
- Pointers are log2(DEPTH) bits and wrap naturally. level is a separate counter: +1 on push only, -1 on pop only.
- Reset mid-operation empties the FIFO; pending entries are lost and overflow clears.

Decomposition:
- Shared package counter_pkg holds:
  - CNT_W and EPOCH_W defaults;
  - TS_W = EPOCH_W+CNT_W;
  - a timestamp typedef {epoch, count}.
- One sub-module: capture_sync_fifo. It is a parameterised synchronous FIFO with push/pop/level/head outputs and no overflow logic.
- Edge detect, wrap/epoch logic and the overflow flag stay in the top.

Test Plan:
1. Reset with trig=1 held, then release; count=0x10 → no capture, rd_valid=0, level=0.
2. Single capture: trig 0→1 while count=0x2A, epoch=0, rd_ready=0 → next cycle rd_valid=1, rd_data=0x02A, level=1. Then rd_ready=1 for 1 cycle → rd_valid=0.
3. Wrap: count 0xFF→0x00 with trig rising on the 0x00 cycle → rd_data=0x100. A later capture at count=0x05 → 0x105. After 16 wraps, epoch returns to 0.
4. Full and overflow:
   - 5 rising edges at count 1,3,5,7,9 with rd_ready=0 → level=4, overflow=1.
   - Drain yields 0x001,0x003,0x005,0x007.
   - ovf_clr → overflow=0.
5. Full with simultaneous pop: level=4, rd_ready=1 and a trig edge at count=0x40 in the same cycle → level stays 4, overflow=0, and 0x040 is the last entry drained.
6. Reset mid-operation: level=3, assert reset for 1 cycle → level=0, rd_valid=0, overflow=0, epoch=0. The next capture at count=0x07 gives rd_data=0x007.
